// File: rtl/memtrace_pkg.sv
// Shared types and default widths for the memory-trace capture path.
// lane_req_t / beat_t describe the default configuration (4 lanes, 64/32/64 bits).
package memtrace_pkg;

  localparam int DEF_NUM_LANES   = 4;
  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_SIZE_WIDTH  = 32;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_CYCLE_WIDTH = 64;

  // Serializer states
  typedef enum logic [0:0] {
    SER_IDLE = 1'b0,
    SER_EMIT = 1'b1
  } ser_state_e;

  // One lane of a request beat
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] address;
    logic                      is_store;
    logic [DEF_SIZE_WIDTH-1:0] size;
    logic [DEF_DATA_WIDTH-1:0] data;
  } lane_req_t;

  // A time-stamped request beat as held in the buffer
  typedef struct packed {
    logic [DEF_CYCLE_WIDTH-1:0]           cycle;
    logic [DEF_NUM_LANES-1:0]             mask;
    lane_req_t [DEF_NUM_LANES-1:0]        lanes;
  } beat_t;

endpackage

// File: rtl/mem_trace_beat_fifo.sv
// Beat buffer for the trace recorder: register-array FIFO of beat records.
// Exposes the head entry and the entry behind it so the serializer can move
// from one beat to the next without an idle cycle.
module mem_trace_beat_fifo
  import memtrace_pkg::*;
#(
  parameter type beat_type = beat_t,
  parameter int  DEPTH     = DEF_FIFO_DEPTH,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  beat_type         push_beat,
  input  logic             pop,
  output beat_type         head,
  output beat_type         second,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  beat_type         mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full   = (count_r == CNT_W'(DEPTH));
  assign empty  = (count_r == CNT_W'(0));
  assign count  = count_r;
  assign head   = mem_r[rd_ptr_r];
  assign second = mem_r[rd_ptr_r + PTR_W'(1)];

  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage write; contents need no reset because occupancy is tracked separately
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_beat;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_trace_recorder.sv
// Memory-trace recorder: time-stamps NUM_LANES-wide request beats, buffers
// them and serializes each beat into one record per active lane.
// Optional feature macro MEMTRACE_RECORD_DPI_EN adds the FILENAME parameter.
module mem_trace_recorder
  import memtrace_pkg::*;
#(
  parameter int NUM_LANES   = DEF_NUM_LANES,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SIZE_WIDTH  = DEF_SIZE_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int CYCLE_WIDTH = DEF_CYCLE_WIDTH
`ifdef MEMTRACE_RECORD_DPI_EN
  , parameter string FILENAME = "undefined"
`endif
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic                             req_ready,
  input  logic [NUM_LANES-1:0]             req_valid,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]  req_address,
  input  logic [NUM_LANES-1:0]             req_is_store,
  input  logic [SIZE_WIDTH*NUM_LANES-1:0]  req_size,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]  req_data,
  input  logic                             req_finished,
  output logic                             rec_valid,
  input  logic                             rec_ready,
  output logic [CYCLE_WIDTH-1:0]           rec_cycle,
  output logic [$clog2(NUM_LANES)-1:0]     rec_tid,
  output logic [DATA_WIDTH-1:0]            rec_address,
  output logic                             rec_is_store,
  output logic [SIZE_WIDTH-1:0]            rec_size,
  output logic [DATA_WIDTH-1:0]            rec_data,
  output logic                             rec_last,
  output logic                             done
);

  localparam int TID_W = $clog2(NUM_LANES);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] address;
    logic                  is_store;
    logic [SIZE_WIDTH-1:0] size;
    logic [DATA_WIDTH-1:0] data;
  } lane_t;

  typedef struct packed {
    logic [CYCLE_WIDTH-1:0]   cycle;
    logic [NUM_LANES-1:0]     mask;
    lane_t [NUM_LANES-1:0]    lanes;
  } rbeat_t;

  // Index of the lowest set lane; the mask is never empty when this is used
  function automatic logic [TID_W-1:0] lowest_lane(input logic [NUM_LANES-1:0] m);
    logic [TID_W-1:0] idx;
    idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = TID_W'(i);
      end
    end
    return idx;
  endfunction

  // True when exactly one lane remains
  function automatic logic single_lane(input logic [NUM_LANES-1:0] m);
    return (m != '0) && ((m & (m - NUM_LANES'(1))) == '0);
  endfunction

  logic [CYCLE_WIDTH-1:0] cycle_r;
  logic                   finished_r;
  logic                   done_r;
  ser_state_e             state_r;
  logic [NUM_LANES-1:0]   remain_r;
  logic                   rec_valid_r;
  logic [CYCLE_WIDTH-1:0] rec_cycle_r;
  logic [TID_W-1:0]       rec_tid_r;
  logic [DATA_WIDTH-1:0]  rec_address_r;
  logic                   rec_is_store_r;
  logic [SIZE_WIDTH-1:0]  rec_size_r;
  logic [DATA_WIDTH-1:0]  rec_data_r;
  logic                   rec_last_r;

  rbeat_t                 push_beat_s;
  rbeat_t                 head_s;
  rbeat_t                 second_s;
  rbeat_t                 src_beat_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [CNT_W-1:0]       fifo_count_s;
  logic                   handshake_s;
  logic                   load_s;
  logic                   go_idle_s;
  logic [NUM_LANES-1:0]   src_mask_s;
  logic [TID_W-1:0]       src_tid_s;
  logic                   done_now_s;

  // Ready is held low while reset is asserted, otherwise it tracks buffer space
  assign req_ready   = reset && !fifo_full_s;
  assign push_s      = req_ready && (req_valid != '0);
  assign handshake_s = rec_valid_r && rec_ready;
  assign pop_s       = handshake_s && rec_last_r;
  assign done_now_s  = finished_r && fifo_empty_s && (state_r == SER_IDLE);
  assign done        = done_r || done_now_s;

  assign rec_valid    = rec_valid_r;
  assign rec_cycle    = rec_cycle_r;
  assign rec_tid      = rec_tid_r;
  assign rec_address  = rec_address_r;
  assign rec_is_store = rec_is_store_r;
  assign rec_size     = rec_size_r;
  assign rec_data     = rec_data_r;
  assign rec_last     = rec_last_r;

  // Pack the incoming lanes and the current time stamp into one beat record
  always_comb begin
    push_beat_s       = '0;
    push_beat_s.cycle = cycle_r;
    push_beat_s.mask  = req_valid;
    for (int g = 0; g < NUM_LANES; g++) begin
      push_beat_s.lanes[g].address  = req_address[DATA_WIDTH*g +: DATA_WIDTH];
      push_beat_s.lanes[g].is_store = req_is_store[g];
      push_beat_s.lanes[g].size     = req_size[SIZE_WIDTH*g +: SIZE_WIDTH];
      push_beat_s.lanes[g].data     = req_data[DATA_WIDTH*g +: DATA_WIDTH];
    end
  end

  mem_trace_beat_fifo #(
    .beat_type (rbeat_t),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_beat (push_beat_s),
    .pop       (pop_s),
    .head      (head_s),
    .second    (second_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Free-running time stamp, restarted by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_r <= '0;
    end else begin
      cycle_r <= cycle_r + CYCLE_WIDTH'(1);
    end
  end

  // Sticky end-of-stream flag and sticky done
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      finished_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      finished_r <= finished_r || req_finished;
      done_r     <= done_r || done_now_s;
    end
  end

  // Decide which beat and lane mask feed the next record. Moving to the next
  // beat uses the entry behind the head, because the head pops this cycle.
  always_comb begin
    load_s     = 1'b0;
    go_idle_s  = 1'b0;
    src_beat_s = head_s;
    src_mask_s = head_s.mask;
    case (state_r)
      SER_IDLE: begin
        if (!fifo_empty_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      SER_EMIT: begin
        if (!handshake_s) begin
          load_s = 1'b0;
        end else if (!rec_last_r) begin
          load_s     = 1'b1;
          src_mask_s = remain_r & ~(NUM_LANES'(1) << rec_tid_r);
        end else if (fifo_count_s >= CNT_W'(2)) begin
          load_s     = 1'b1;
          src_beat_s = second_s;
          src_mask_s = second_s.mask;
        end else begin
          go_idle_s = 1'b1;
        end
      end
      default: begin
        go_idle_s = 1'b1;
      end
    endcase
    src_tid_s = lowest_lane(src_mask_s);
  end

  // Serializer FSM with registered record outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= SER_IDLE;
      remain_r       <= '0;
      rec_valid_r    <= 1'b0;
      rec_cycle_r    <= '0;
      rec_tid_r      <= '0;
      rec_address_r  <= '0;
      rec_is_store_r <= 1'b0;
      rec_size_r     <= '0;
      rec_data_r     <= '0;
      rec_last_r     <= 1'b0;
    end else if (load_s) begin
      state_r        <= SER_EMIT;
      remain_r       <= src_mask_s;
      rec_valid_r    <= 1'b1;
      rec_cycle_r    <= src_beat_s.cycle;
      rec_tid_r      <= src_tid_s;
      rec_address_r  <= src_beat_s.lanes[src_tid_s].address;
      rec_is_store_r <= src_beat_s.lanes[src_tid_s].is_store;
      rec_size_r     <= src_beat_s.lanes[src_tid_s].size;
      rec_data_r     <= src_beat_s.lanes[src_tid_s].data;
      rec_last_r     <= single_lane(src_mask_s);
    end else if (go_idle_s) begin
      state_r     <= SER_IDLE;
      remain_r    <= '0;
      rec_valid_r <= 1'b0;
      rec_last_r  <= 1'b0;
    end else begin
      state_r <= state_r;
    end
  end

endmodule
